// File: rtl/my_fifo_ctrl.sv
// Synchronous FIFO controller for an external dual-port RAM with an asynchronous read port.
// Tracks occupancy through wrap-bit pointers and produces status, threshold and error flags.
module my_fifo_ctrl #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = DEPTH - 2,
    parameter int AE_LVL = 2,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_wren,
    input  logic [DATA_W-1:0] i_wrdata,
    input  logic              i_rden,
    output logic [DATA_W-1:0] o_rddata,
    output logic              o_rdvalid,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_alm_full,
    output logic              o_alm_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_ovf,
    output logic              o_udf,
    output logic              o_ram_en,
    output logic              o_ram_wren,
    output logic [ADDR_W-1:0] o_ram_waddr,
    output logic [ADDR_W-1:0] o_ram_raddr,
    output logic [DATA_W-1:0] o_ram_wdata,
    input  logic [DATA_W-1:0] i_ram_rdata
);

    localparam logic [ADDR_W:0] AF_THR = (ADDR_W+1)'(AF_LVL);
    localparam logic [ADDR_W:0] AE_THR = (ADDR_W+1)'(AE_LVL);
    localparam logic [ADDR_W:0] PTR_ONE = (ADDR_W+1)'(1);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [ADDR_W:0]   cnt;
    logic [DATA_W-1:0] rd_data_p1;
    logic              rd_vld_p1;
    logic              ovf_p1;
    logic              udf_p1;
    logic              wr_ok;
    logic              rd_ok;

    // Flags come from the registered pointers, so same-cycle requests never see their own effect.
    assign o_empty = (wr_ptr == rd_ptr);
    assign o_full  = (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]) &&
                     (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]);

    assign wr_ok = i_wren & ~o_full & ~rst;
    assign rd_ok = i_rden & ~o_empty & ~rst;

    assign o_ram_en    = ~rst;
    assign o_ram_wren  = wr_ok;
    assign o_ram_waddr = wr_ptr[ADDR_W-1:0];
    assign o_ram_raddr = rd_ptr[ADDR_W-1:0];
    assign o_ram_wdata = i_wrdata;

    assign o_count     = cnt;
    assign o_alm_full  = (cnt >= AF_THR);
    assign o_alm_empty = (cnt <= AE_THR);

    assign o_rddata  = rd_data_p1;
    assign o_rdvalid = rd_vld_p1;
    assign o_ovf     = ovf_p1;
    assign o_udf     = udf_p1;

    // Stage p1: pointer/count update and registered read data, valid and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            cnt        <= '0;
            rd_data_p1 <= '0;
            rd_vld_p1  <= 1'b0;
            ovf_p1     <= 1'b0;
            udf_p1     <= 1'b0;
        end else begin
            if (wr_ok)
                wr_ptr <= wr_ptr + PTR_ONE;
            if (rd_ok) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                rd_data_p1 <= i_ram_rdata;
            end
            case ({wr_ok, rd_ok})
                2'b10:   cnt <= cnt + PTR_ONE;
                2'b01:   cnt <= cnt - PTR_ONE;
                default: cnt <= cnt;
            endcase
            rd_vld_p1 <= rd_ok;
            ovf_p1    <= i_wren & o_full;
            udf_p1    <= i_rden & o_empty;
        end
    end

endmodule
